// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the FSM state encoding, the fault codes reported to decode, and the
// boot PC used by benches and the PC generator.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_ACCESS   = 2'b10;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Purpose: fetch stage; one imem request in flight, result buffered for decode.
// Latency: pc accepted at N, response at N+k -> inst_valid at N+k+1.
// Backpressure: pc_ready low outside IDLE and during flush; inst held until inst_ready.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   pc_valid/pc/pc_ready           fetch address from the PC generator
//   flush                          redirect; kills the current fetch
//   imem_req_valid/ready/addr      request channel to instruction memory
//   imem_rsp_valid/data/err        single-cycle response from memory
//   inst_valid/ready, inst,
//   inst_pc, inst_fault            instruction handed to decode
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int DW = 64,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pc_valid,
  input  logic [DW-1:0] pc,
  output logic          pc_ready,
  input  logic          flush,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [DW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  input  logic          imem_rsp_err,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [IW-1:0] inst,
  output logic [DW-1:0] inst_pc,
  output logic [1:0]    inst_fault
);

  state_t        state_q, state_d;
  logic [DW-1:0] pc_q;
  logic [IW-1:0] inst_q, inst_d;
  logic [DW-1:0] inst_pc_q, inst_pc_d;
  logic [1:0]    fault_q, fault_d;
  logic          inst_valid_q;
  logic          ld_pc, ld_inst;
  logic          aligned;

  assign aligned       = (pc[1:0] == 2'b00);
  assign imem_req_addr = pc;

  always_comb begin
    state_d        = state_q;
    pc_ready       = 1'b0;
    imem_req_valid = 1'b0;
    ld_pc          = 1'b0;
    ld_inst        = 1'b0;
    inst_d         = '0;
    inst_pc_d      = pc_q;
    fault_d        = FLT_NONE;

    case (state_q)
      ST_IDLE: begin
        // Qualified by rstn so nothing leaks out while reset is held.
        imem_req_valid = rstn & pc_valid & ~flush & aligned;
        // Misaligned addresses are consumed locally without touching memory.
        pc_ready       = rstn & ~flush & (imem_req_ready | ~aligned);
        if (imem_req_valid && imem_req_ready) begin
          ld_pc   = 1'b1;
          state_d = ST_WAIT;
        end else if (rstn && pc_valid && !flush && !aligned) begin
          ld_inst   = 1'b1;
          inst_pc_d = pc;
          fault_d   = FLT_MISALIGN;
          state_d   = ST_HOLD;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            ld_inst   = 1'b1;
            inst_d    = imem_rsp_err ? '0 : imem_rsp_data;
            inst_pc_d = pc_q;
            fault_d   = imem_rsp_err ? FLT_ACCESS : FLT_NONE;
            state_d   = ST_HOLD;
          end
        end else if (flush) begin
          // Response still owed by memory; swallow it in DROP.
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        // Flush discards the buffered instruction, same exit as a handshake.
        if (flush || inst_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      fault_q      <= FLT_NONE;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= (state_d == ST_HOLD);
      if (ld_pc) pc_q <= pc;
      if (ld_inst) begin
        inst_q    <= inst_d;
        inst_pc_q <= inst_pc_d;
        fault_q   <= fault_d;
      end
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = fault_q;

  // Memory must only respond while a request is outstanding.
  a_rsp_when_pending : assert property (
    @(posedge clk) disable iff (!rstn)
    imem_rsp_valid |-> (state_q == ST_WAIT || state_q == ST_DROP)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk;
  logic        rstn;
  logic        pc_valid;
  logic [63:0] pc;
  logic        pc_ready;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [1:0]  inst_fault;

  int checks   = 0;
  int failures = 0;

  ifu_fetch #(.DW(64), .IW(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .pc_valid       (pc_valid),
    .pc             (pc),
    .pc_ready       (pc_ready),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rstn = 1'b0; pc_valid = 1'b1; pc = RESET_PC; flush = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    imem_rsp_err = 1'b0; inst_ready = 1'b0;

    // Reset held with a valid PC on the input.
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("rst_pc_ready", {63'd0, pc_ready}, 64'd0);
      chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    end
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_fault", {62'd0, inst_fault}, 64'd0);

    // Release; memory not ready yet, then ready.
    imem_req_ready = 1'b0; rstn = 1'b1; settle();
    chk("boot_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("boot_req_addr", imem_req_addr, 64'h8000_0000);
    chk("boot_pc_ready_stalled", {63'd0, pc_ready}, 64'd0);
    imem_req_ready = 1'b1; settle();
    chk("boot_pc_ready", {63'd0, pc_ready}, 64'd1);

    // Normal fetch: WAIT, 1-cycle response.
    tick(); pc_valid = 1'b0; imem_req_ready = 1'b0; settle();
    chk("wait_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("wait_pc_ready", {63'd0, pc_ready}, 64'd0);
    chk("wait_inst_valid", {63'd0, inst_valid}, 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0413;
    tick(); imem_rsp_valid = 1'b0; imem_rsp_data = '0; settle();
    chk("norm_inst_valid", {63'd0, inst_valid}, 64'd1);
    chk("norm_inst", {32'd0, inst}, 64'h0000_0413);
    chk("norm_inst_pc", inst_pc, 64'h8000_0000);
    chk("norm_fault", {62'd0, inst_fault}, {62'd0, FLT_NONE});

    // Decode stall for 5 cycles with a new PC offered.
    pc_valid = 1'b1; pc = 64'h8000_0004; imem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("stall_inst", {32'd0, inst}, 64'h0000_0413);
      chk("stall_inst_pc", inst_pc, 64'h8000_0000);
      chk("stall_pc_ready", {63'd0, pc_ready}, 64'd0);
      chk("stall_req_valid", {63'd0, imem_req_valid}, 64'd0);
      tick();
    end
    inst_ready = 1'b1;
    tick(); inst_ready = 1'b0; settle();
    chk("after_hs_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("after_hs_pc_ready", {63'd0, pc_ready}, 64'd1);
    chk("after_hs_req_addr", imem_req_addr, 64'h8000_0004);

    // Flush in WAIT before the response: DROP swallows it.
    tick(); pc_valid = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0; pc_valid = 1'b1; pc = 64'h8000_0100; settle();
    chk("drop_pc_ready", {63'd0, pc_ready}, 64'd0);
    chk("drop_req_valid", {63'd0, imem_req_valid}, 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick(); imem_rsp_valid = 1'b0; imem_rsp_data = '0; settle();
    chk("drop_no_inst", {63'd0, inst_valid}, 64'd0);
    chk("redir_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("redir_req_addr", imem_req_addr, 64'h8000_0100);
    tick(); pc_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    tick(); imem_rsp_valid = 1'b0; settle();
    chk("redir_inst", {32'd0, inst}, 64'h1234_5678);
    chk("redir_inst_pc", inst_pc, 64'h8000_0100);
    inst_ready = 1'b1;
    tick(); inst_ready = 1'b0;

    // Misaligned PC: no request, fault reported.
    pc_valid = 1'b1; pc = 64'h8000_0002; imem_req_ready = 1'b0; settle();
    chk("mis_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("mis_pc_ready", {63'd0, pc_ready}, 64'd1);
    tick(); pc_valid = 1'b0; settle();
    chk("mis_inst_valid", {63'd0, inst_valid}, 64'd1);
    chk("mis_fault", {62'd0, inst_fault}, {62'd0, FLT_MISALIGN});
    chk("mis_inst", {32'd0, inst}, 64'd0);
    chk("mis_inst_pc", inst_pc, 64'h8000_0002);
    inst_ready = 1'b1;
    tick(); inst_ready = 1'b0;

    // Access fault, response two cycles after accept.
    pc_valid = 1'b1; pc = 64'h8000_0008; imem_req_ready = 1'b1;
    tick(); pc_valid = 1'b0;
    tick(); settle();
    chk("err_wait_k2", {63'd0, inst_valid}, 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'hFFFF_FFFF;
    tick(); imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = '0; settle();
    chk("err_inst_valid", {63'd0, inst_valid}, 64'd1);
    chk("err_fault", {62'd0, inst_fault}, {62'd0, FLT_ACCESS});
    chk("err_inst", {32'd0, inst}, 64'd0);
    chk("err_inst_pc", inst_pc, 64'h8000_0008);

    // Flush together with inst_ready in HOLD.
    flush = 1'b1; inst_ready = 1'b1; pc_valid = 1'b1; pc = 64'h8000_000C; settle();
    chk("hold_flush_pc_ready", {63'd0, pc_ready}, 64'd0);
    chk("hold_flush_req_valid", {63'd0, imem_req_valid}, 64'd0);
    tick(); flush = 1'b0; inst_ready = 1'b0; settle();
    chk("hold_flush_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("hold_flush_idle", {63'd0, pc_ready}, 64'd1);

    // Flush together with response in WAIT: straight back to IDLE.
    tick(); pc_valid = 1'b0; flush = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_AAAA;
    tick(); flush = 1'b0; imem_rsp_valid = 1'b0; pc_valid = 1'b1; pc = 64'h8000_0010; settle();
    chk("wait_flush_rsp_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("wait_flush_rsp_idle", {63'd0, pc_ready}, 64'd1);
    chk("wait_flush_rsp_req", {63'd0, imem_req_valid}, 64'd1);

    // Asynchronous reset while a fetch is outstanding.
    tick(); pc_valid = 1'b0; rstn = 1'b0; settle();
    chk("midrst_inst_pc", inst_pc, 64'd0);
    chk("midrst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    tick(); rstn = 1'b1; pc_valid = 1'b1; pc = 64'h8000_0020; settle();
    chk("midrst_idle", {63'd0, pc_ready}, 64'd1);
    chk("midrst_req_addr", imem_req_addr, 64'h8000_0020);
    chk("midrst_inst_valid", {63'd0, inst_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
